// File: rtl/fetch_controller_if.sv
// fetch_controller_if: request inputs and fetch-control outputs of the fetch controller
interface fetch_controller_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 halt;
  logic                 stall;
  logic                 br_taken;
  logic [PC_WIDTH-1:0]  br_target;
  logic                 jmp;
  logic [PC_WIDTH-1:0]  jmp_target;
  logic                 ce;
  logic                 change_pc;
  logic [PC_WIDTH-1:0]  pc;
  logic                 flush_if;
  logic                 flush_id;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] redir_cnt;
  modport master (
    input  start, halt, stall, br_taken, br_target, jmp, jmp_target,
    output ce, change_pc, pc, flush_if, flush_id, state, redir_cnt
  );
  modport slave (
    output start, halt, stall, br_taken, br_target, jmp, jmp_target,
    input  ce, change_pc, pc, flush_if, flush_id, state, redir_cnt
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: sequences instruction fetch (boot, redirects, stalls, halt) and flush strobes
module fetch_controller #(
  parameter int                   PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int                   CNT_WIDTH = 16
) (
  input logic               fc_clk,
  input logic               fc_rst,
  fetch_controller_if.master fc
);
  typedef enum logic [2:0] {IDLE, BOOT, RUN, STALL, REDIRECT, HALTED} state_t;
  state_t              state_q, nxt;
  logic [PC_WIDTH-1:0] nxt_pc;
  logic                nxt_fi, nxt_fd;
  always_comb begin
    nxt    = state_q;
    nxt_pc = fc.pc;
    nxt_fi = 1'b0;
    nxt_fd = 1'b0;
    case (state_q)
      IDLE: if (fc.start) begin
        nxt    = BOOT;
        nxt_pc = RESET_PC;
      end
      BOOT:     nxt = RUN;
      REDIRECT: nxt = fc.halt ? HALTED : RUN;
      HALTED:   nxt = fc.start ? RUN : HALTED;
      RUN, STALL: begin
        // branch outranks jump: the jump sits on the wrong path of the branch
        if (fc.halt) nxt = HALTED;
        else if (fc.br_taken) begin
          nxt    = REDIRECT;
          nxt_pc = fc.br_target;
          nxt_fi = 1'b1;
          nxt_fd = 1'b1;
        end else if (fc.jmp) begin
          nxt    = REDIRECT;
          nxt_pc = fc.jmp_target;
          nxt_fi = 1'b1;
        end else nxt = fc.stall ? STALL : RUN;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      state_q      <= IDLE;
      fc.ce        <= 1'b0;
      fc.change_pc <= 1'b0;
      fc.pc        <= RESET_PC;
      fc.flush_if  <= 1'b0;
      fc.flush_id  <= 1'b0;
      fc.redir_cnt <= '0;
    end else begin
      state_q      <= nxt;
      fc.ce        <= nxt == RUN;
      fc.change_pc <= nxt == BOOT || nxt == REDIRECT;
      fc.pc        <= nxt_pc;
      fc.flush_if  <= nxt_fi;
      fc.flush_id  <= nxt_fd;
      fc.redir_cnt <= (nxt == REDIRECT && !(&fc.redir_cnt)) ? fc.redir_cnt + 1'b1 : fc.redir_cnt;
    end
  end
  assign fc.state = state_q;
endmodule
